rom_download_writer: RTL and testbench

- Sits between the HPS ioctl download port and the SDRAM controller, on the ROM-load path.
- Accepts the byte stream written during a ROM download and packs bytes into 32-bit little-endian words.
- Buffers packed words in a small FIFO and writes them to SDRAM through the controller's req/ack handshake.
- Reports busy/done so the top level holds the game in reset until every ROM byte is in SDRAM.

---
 rtl/rom_download_writer.sv | 152 +++++++++++++++
 tb/tb_rom_download_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_writer.sv
// rom_download_writer: packs ioctl download bytes into 32-bit words and writes them to SDRAM via req/ack.
// Optional macro ROM_DOWNLOAD_CHECKSUM_EN adds a 16-bit checksum output over accepted download bytes.
module rom_download_writer #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [22:0] ADDR_OFFSET = 23'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        ioctl_download,
    output logic [22:0] sdram_addr,
    output logic [31:0] sdram_data,
    output logic        sdram_we,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_GAP} state_t;
    state_t state, state_nx;
    logic        dl_q, push_full;
    logic [31:0] pend_data;
    logic [3:0]  pend_valid, held;
    logic [22:0] pend_waddr, wr_waddr;
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [22:0] fifo_addr [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        wr_ok, dl_rise, dl_fall, new_word, push, pop, push_ok;
    logic        fifo_empty, fifo_full, busy_nx;
    logic [31:0] push_data;
    // Packer decode: a word already queued for push by a lane-3 write no longer counts as held.
    always_comb begin
        wr_ok      = ioctl_wr & ioctl_download;
        dl_rise    = ioctl_download & ~dl_q;
        dl_fall    = ~ioctl_download & dl_q;
        held       = push_full ? 4'b0 : pend_valid;
        wr_waddr   = ioctl_addr[24:2];
        new_word   = wr_ok && held != 4'b0 && wr_waddr != pend_waddr;
        push       = push_full | new_word | (dl_fall && held != 4'b0);
        push_data  = pend_data & {{8{pend_valid[3]}}, {8{pend_valid[2]}}, {8{pend_valid[1]}}, {8{pend_valid[0]}}};
        fifo_empty = wptr == rptr;
        fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        pop        = state == REQ && sdram_ack;
        push_ok    = push && (!fifo_full || pop);
        busy_nx    = ioctl_download | (pend_valid != 4'b0) | !fifo_empty | (state != IDLE);
        sdram_we   = sdram_req;
    end
    // Byte packer: load lanes, start a fresh word on discontinuity, clear lanes once pushed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            push_full  <= 1'b0;
            pend_valid <= 4'b0;
            pend_data  <= 32'd0;
            pend_waddr <= 23'd0;
        end else begin
            dl_q      <= ioctl_download;
            push_full <= wr_ok && ioctl_addr[1:0] == 2'd3;
            if (wr_ok) begin
                pend_valid <= (new_word ? 4'b0 : held) | (4'b1 << ioctl_addr[1:0]);
                pend_data[{ioctl_addr[1:0], 3'b000} +: 8] <= ioctl_data;
                pend_waddr <= wr_waddr;
            end else if (push) begin
                pend_valid <= 4'b0;
            end
        end
    end
    // Sticky overflow: a push was needed while the FIFO was full and nothing was popping.
    always_ff @(posedge clk) begin
        if (!reset_n || dl_rise)
            overflow <= 1'b0;
        else if (push && !push_ok)
            overflow <= 1'b1;
    end
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    // Running byte sum restarts with each download; a byte arriving on the first cycle still counts.
    always_ff @(posedge clk) begin
        if (!reset_n)
            checksum <= 16'd0;
        else
            checksum <= (dl_rise ? 16'd0 : checksum) + (wr_ok ? {8'd0, ioctl_data} : 16'd0);
    end
`endif
    // FIFO storage: contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wptr[AW-1:0]] <= push_data;
            fifo_addr[wptr[AW-1:0]] <= pend_waddr + ADDR_OFFSET;
        end
    end
    // FIFO pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end
    // Writer state register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // Writer next state: issue, wait for ack, then one gap cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = fifo_empty ? IDLE : REQ;
            REQ:      state_nx = sdram_ack ? WAIT_GAP : REQ;
            WAIT_GAP: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    // SDRAM request outputs are registered and held stable for the whole request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sdram_req  <= 1'b0;
            sdram_addr <= 23'd0;
            sdram_data <= 32'd0;
        end else begin
            sdram_req <= state_nx == REQ;
            if (state == IDLE && !fifo_empty) begin
                sdram_addr <= fifo_addr[rptr[AW-1:0]];
                sdram_data <= fifo_data[rptr[AW-1:0]];
            end
        end
    end
    // Busy is registered so reset forces it low; done marks its falling edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= busy & ~busy_nx;
        end
    end
endmodule

// File: tb/tb_rom_download_writer.sv
// tb_rom_download_writer: directed checks of packing, gaps, overflow, reset and checksum.
module tb_rom_download_writer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [22:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        we_a, we_b, req_a, req_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic        ack_a = 1'b0, ack_b = 1'b0;
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    logic [15:0] sum_a, sum_b;
`endif
    logic [22:0] qa_addr[$], qb_addr[$];
    logic [31:0] qa_data[$], qb_data[$];
    int done_a_cnt = 0, dly_a = 0, cnt_a = 0;
    int dly_b = 0, cnt_b = 0;
    int checks = 0, errors = 0;

    rom_download_writer u_a (
        .clk(clk), .reset_n(reset_n), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download), .sdram_addr(addr_a),
        .sdram_data(data_a), .sdram_we(we_a), .sdram_req(req_a), .sdram_ack(ack_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a)
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
        , .checksum(sum_a)
`endif
    );

    rom_download_writer #(.FIFO_DEPTH(2), .ADDR_OFFSET(23'h100000)) u_b (
        .clk(clk), .reset_n(reset_n), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download), .sdram_addr(addr_b),
        .sdram_data(data_b), .sdram_we(we_b), .sdram_req(req_b), .sdram_ack(ack_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b)
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
        , .checksum(sum_b)
`endif
    );

    always #5 clk = ~clk;

    // SDRAM model A: ack after dly_a cycles of req, logging each accepted write.
    always @(negedge clk) begin
        if (done_a) done_a_cnt++;
        if (ack_a) ack_a = 1'b0;
        else if (req_a) begin
            if (cnt_a >= dly_a) begin
                ack_a = 1'b1; cnt_a = 0;
                qa_addr.push_back(addr_a); qa_data.push_back(data_a);
            end else cnt_a++;
        end else cnt_a = 0;
    end

    // SDRAM model B: stalls dly_b cycles on every other write only.
    always @(negedge clk) begin
        if (ack_b) ack_b = 1'b0;
        else if (req_b) begin
            if (cnt_b >= ((qb_addr.size() % 2 == 0) ? dly_b : 0)) begin
                ack_b = 1'b1; cnt_b = 0;
                qb_addr.push_back(addr_b); qb_data.push_back(data_b);
            end else cnt_b++;
        end else cnt_b = 0;
    end

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk); ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
        @(negedge clk); ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        @(negedge clk);
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
        done_a_cnt = 0;
        ioctl_download = 1'b1;
    endtask

    task automatic end_dl();
        int n;
        @(negedge clk); ioctl_download = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while ((busy_a || busy_b) && n < 3000);
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a || busy_b) begin errors++; $display("FAIL idle_timeout busy_a=%0b busy_b=%0b expected 0", busy_a, busy_b); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks += 7;
        if (req_a !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req_a); end
        if (we_a !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", we_a); end
        if (addr_a !== 23'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr_a); end
        if (data_a !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", data_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
        if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", ovf_a); end
    endtask

    task automatic test_pack();
        logic [31:0] ed [2] = '{32'h03020100, 32'h07060504};
        start_dl();
        for (int i = 0; i < 8; i++) put_byte(25'(i), 8'(i));
        end_dl();
        checks += 3;
        if (qa_data.size() != 2) begin errors++; $display("FAIL pack_count got %0d exp 2", qa_data.size()); end
        if (done_a_cnt != 1) begin errors++; $display("FAIL pack_done got %0d exp 1", done_a_cnt); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL pack_busy got %b exp 0", busy_a); end
        for (int i = 0; i < 2 && i < qa_data.size(); i++) begin
            checks += 2;
            if (qa_data[i] !== ed[i]) begin errors++; $display("FAIL pack_data%0d got %h exp %h", i, qa_data[i], ed[i]); end
            if (qa_addr[i] !== 23'(i)) begin errors++; $display("FAIL pack_addr%0d got %h exp %h", i, qa_addr[i], i); end
        end
    endtask

    task automatic test_partial();
        logic [31:0] ed [2] = '{32'h14131211, 32'h00000015};
        start_dl();
        for (int i = 0; i < 5; i++) put_byte(25'(i), 8'(8'h11 + i));
        end_dl();
        checks += 2;
        if (qa_data.size() != 2) begin errors++; $display("FAIL partial_count got %0d exp 2", qa_data.size()); end
        if (done_a_cnt != 1) begin errors++; $display("FAIL partial_done got %0d exp 1", done_a_cnt); end
        for (int i = 0; i < 2 && i < qa_data.size(); i++) begin
            checks += 2;
            if (qa_data[i] !== ed[i]) begin errors++; $display("FAIL partial_data%0d got %h exp %h", i, qa_data[i], ed[i]); end
            if (qa_addr[i] !== 23'(i)) begin errors++; $display("FAIL partial_addr%0d got %h exp %h", i, qa_addr[i], i); end
        end
    endtask

    task automatic test_discontinuity();
        logic [31:0] ed [2] = '{32'h0000BBAA, 32'h000000CC};
        logic [22:0] ea [2] = '{23'd0, 23'd2};
        start_dl();
        put_byte(25'd0, 8'hAA);
        put_byte(25'd1, 8'hBB);
        put_byte(25'd8, 8'hCC);
        end_dl();
        checks++;
        if (qa_data.size() != 2) begin errors++; $display("FAIL disc_count got %0d exp 2", qa_data.size()); end
        for (int i = 0; i < 2 && i < qa_data.size(); i++) begin
            checks += 2;
            if (qa_data[i] !== ed[i]) begin errors++; $display("FAIL disc_data%0d got %h exp %h", i, qa_data[i], ed[i]); end
            if (qa_addr[i] !== ea[i]) begin errors++; $display("FAIL disc_addr%0d got %h exp %h", i, qa_addr[i], ea[i]); end
        end
    endtask

    task automatic test_overflow();
        dly_b = 50;
        start_dl();
        for (int i = 0; i < 16; i++) put_byte(25'(i), 8'(i));
        end_dl();
        checks += 2;
        if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_b); end
        if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_deep_fifo got %b exp 0", ovf_a); end
    endtask

    task automatic test_stall_ok();
        logic [31:0] ed [4] = '{32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};
        dly_b = 10;
        start_dl();
        repeat (2) @(negedge clk);
        checks++;
        if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_start got %b exp 0", ovf_b); end
        for (int i = 0; i < 16; i++) put_byte(25'(i), 8'(8'h40 + i));
        end_dl();
        checks += 2;
        if (ovf_b !== 1'b0) begin errors++; $display("FAIL stall_ovf got %b exp 0", ovf_b); end
        if (qb_data.size() != 4) begin errors++; $display("FAIL stall_count got %0d exp 4", qb_data.size()); end
        for (int i = 0; i < 4 && i < qb_data.size(); i++) begin
            checks += 2;
            if (qb_data[i] !== ed[i]) begin errors++; $display("FAIL stall_data%0d got %h exp %h", i, qb_data[i], ed[i]); end
            if (qb_addr[i] !== 23'(23'h100000 + i)) begin errors++; $display("FAIL stall_addr%0d got %h exp %h", i, qb_addr[i], 23'h100000 + i); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        dly_a = 1000;
        start_dl();
        for (int i = 0; i < 4; i++) put_byte(25'(i), 8'(8'h30 + i));
        @(negedge clk); ioctl_download = 1'b0;
        n = 0;
        while (!req_a && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (req_a !== 1'b1) begin errors++; $display("FAIL rst_mid_req_up got %b exp 1", req_a); end
        reset_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (req_a !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b exp 0", req_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_a); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done_a); end
        reset_n = 1'b1;
        dly_a = 0;
        repeat (5) @(negedge clk);
        checks += 2;
        if (done_a_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d exp 0", done_a_cnt); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %b exp 0", busy_a); end
        start_dl();
        for (int i = 0; i < 4; i++) put_byte(25'(25'h10 + i), 8'(8'h21 + i));
        end_dl();
        checks += 4;
        if (qa_data.size() != 1) begin errors++; $display("FAIL fresh_count got %0d exp 1", qa_data.size()); end
        if (qa_data.size() > 0 && qa_data[0] !== 32'h24232221) begin errors++; $display("FAIL fresh_data got %h exp 24232221", qa_data[0]); end
        if (qa_addr.size() > 0 && qa_addr[0] !== 23'd4) begin errors++; $display("FAIL fresh_addr got %h exp 4", qa_addr[0]); end
        if (done_a_cnt != 1) begin errors++; $display("FAIL fresh_done got %0d exp 1", done_a_cnt); end
    endtask

`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    task automatic test_checksum();
        start_dl();
        for (int i = 0; i < 300; i++) put_byte(25'(i), 8'hFF);
        end_dl();
        checks += 2;
        if (sum_a !== 16'h2AD4) begin errors++; $display("FAIL checksum got %h exp 2ad4", sum_a); end
        if (done_a_cnt != 1) begin errors++; $display("FAIL checksum_done got %0d exp 1", done_a_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_pack();
        test_partial();
        test_discontinuity();
        test_overflow();
        test_stall_ok();
        test_reset_mid();
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
